cov_stream_tx: RTL and testbench
================================

Name: cov_stream_tx

Overview:
- Transmit-side companion to the covariance update stage.
- On the update stage's done signal, snapshots the full parallel posterior covariance P_kk (STATE_DIM x STATE_DIM, IEEE-754 double).
- Streams the snapshot out one element per beat over a valid/ready interface, in row-major order, with row/col tags.
- Feeds the next predict iteration or a host readback path, so the parallel matrix bus ends at this block.

Parameters:
- STATE_DIM, 12, matrix dimension (rows = cols).
- DWIDTH, 64, element width (FP64 bit pattern; passed through untouched).
- IDX_W, $clog2(STATE_DIM), width of the row/col tags.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- P_kk  in  DWIDTH x [STATE_DIM][STATE_DIM]  parallel covariance matrix from the update stage.
- SCU_Done  in  1  update-complete; may be a pulse or held high; only its rising edge starts a transfer.
- m_data  out  DWIDTH  current element.
- m_row  out  IDX_W  row index of m_data.
- m_col  out  IDX_W  column index of m_data.
- m_valid  out  1  beat valid.
- m_ready  in  1  downstream accept.
- m_last  out  1  high on the final beat of a matrix.
- busy  out  1  high from capture until the last beat is accepted.
- tx_done  out  1  one-cycle pulse after the last beat is accepted.
- overrun  out  1  sticky: a start arrived while busy.

Behaviour:
- Single clock domain; asynchronous active-low reset; all state on clk rising edge.
- Reset values: m_data=0, m_row=0, m_col=0, m_valid=0, m_last=0, busy=0, tx_done=0, overrun=0, FSM=IDLE, shadow matrix=0, SCU_Done edge register=0.
- Start event: SCU_Done==1 while the registered previous SCU_Done==0.
- FSM IDLE: on a start event, latch all of P_kk into the shadow array, set busy=1 and row=col=0, then go to SEND. No other effect.
- FSM SEND: m_valid=1 and m_data=shadow[m_row][m_col]. A beat is accepted when m_valid && m_ready.
  - On accept with col<STATE_DIM-1: increment col.
  - On accept with col==STATE_DIM-1: col wraps to the row-start column and row increments.
  - On accept of the last element: go to DONE.
- FSM DONE: lasts one cycle. Drives m_valid=0, busy=0, tx_done=1, then returns to IDLE.
- Latency: first beat is valid on the cycle after the start-event edge. Minimum matrix time with m_ready tied high is STATE_DIM*STATE_DIM beats plus 2 cycles.
- Handshake: while m_valid && !m_ready, m_data, m_row, m_col and m_last hold stable. m_valid never drops before the beat is accepted. m_valid is independent of m_ready (no combinational path from m_ready to m_valid).
- m_last = 1 exactly when (m_row, m_col) is the final index of the current traversal.
- P_kk changing during SEND does not affect output, because streaming reads only the shadow array.
- Start event during SEND or DONE: ignored, overrun set to 1; overrun clears only on reset.
- SCU_Done held high through the end of a transfer does not retrigger; a new rising edge is required.
- A start event in the same cycle that DONE returns to IDLE is treated as in DONE: ignored, overrun set.
- Reset asserted mid-stream: everything returns to reset values immediately; the partial matrix is abandoned and no tx_done is issued.

Optional Feature:
- Macro: COV_UPPER_TRI_EN.
- Defined: only elements with col >= row are sent, i.e. STATE_DIM*(STATE_DIM+1)/2 = 78 beats at default. After each row the column wraps to the new row index. m_last marks (STATE_DIM-1, STATE_DIM-1). This exploits covariance symmetry.
- Undefined: the full STATE_DIM*STATE_DIM = 144 beats in row-major order, with the column wrapping to 0.

Decomposition:
- Package kf_pkg: STATE_DIM and DWIDTH defaults, the idx_t typedef (logic [IDX_W-1:0]), the cov_tx_state_e enum {IDLE, SEND, DONE}, and the FP64 constants used elsewhere (FP_ONE = 64'h3FF0000000000000, FP_ZERO).
- One natural sub-module, cov_index_walker. It holds the row/col counters, the advance-on-accept logic, the wrap rule (the COV_UPPER_TRI_EN variant lives here) and is_last generation. The top level keeps the FSM, shadow array, edge detect and output muxing.

Test Plan:
- m_ready=1, P_kk[i][j] = {i,j} encoded as 64'h(i*16+j), single SCU_Done pulse -> 144 beats in row-major order, each m_data matching its tags. m_last only at (11,11). tx_done pulses one cycle after that beat; busy is low afterwards.
- m_ready toggled pseudo-randomly (~50%) -> no beat is lost or duplicated, and data/tags are stable across every stalled cycle.
- P_kk rewritten to all 64'hDEADBEEF... on the cycle after capture -> every streamed value is still the captured pattern.
- Second SCU_Done rising edge at beat 40 -> the stream continues unaffected, overrun=1 and stays 1. SCU_Done held high for 300 cycles -> exactly one transfer.
- rst_n pulled low at beat 70, then released, then a new SCU_Done -> all outputs read 0 during reset, with no tx_done. The new transfer starts at (0,0) and completes all 144 beats.
- With COV_UPPER_TRI_EN defined -> 78 beats. The sequence starts (0,0)..(0,11),(1,1)...; m_last is at (11,11); no beat has col<row.

Source files
------------

// File: rtl/kf_pkg.sv
// kf_pkg: shared Kalman-filter datapath types, default dimensions and FP64 constants.
package kf_pkg;

    localparam int STATE_DIM = 12;
    localparam int DWIDTH    = 64;
    localparam int IDX_W     = $clog2(STATE_DIM);

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic [1:0] {IDLE, SEND, DONE} cov_tx_state_e;

    localparam logic [63:0] FP_ONE  = 64'h3FF0000000000000;
    localparam logic [63:0] FP_ZERO = 64'h0000000000000000;

endpackage

// File: rtl/cov_index_walker.sv
// cov_index_walker: row/col traversal counters for the covariance stream.
// COV_UPPER_TRI_EN restricts the walk to the upper triangle (col >= row).
module cov_index_walker
    import kf_pkg::*;
#(
    parameter int STATE_DIM = kf_pkg::STATE_DIM,
    parameter int IDX_W     = $clog2(STATE_DIM)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             advance,
    output logic [IDX_W-1:0] row,
    output logic [IDX_W-1:0] col,
    output logic             is_last
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(STATE_DIM - 1);

    logic [IDX_W-1:0] row_nx, col_nx, row_inc;
    logic             col_end;

    always_comb begin
        col_end = col == LAST;
        row_inc = row + 1'b1;
`ifdef COV_UPPER_TRI_EN
        col_nx  = col_end ? row_inc : col + 1'b1;
`else
        col_nx  = col_end ? '0 : col + 1'b1;
`endif
        row_nx  = col_end ? row_inc : row;
        is_last = col_end && row == LAST;
    end

    // Rewind after the final beat so the counters never leave the matrix.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (clear || (advance && is_last)) begin
            row <= '0;
            col <= '0;
        end else if (advance) begin
            row <= row_nx;
            col <= col_nx;
        end

endmodule

// File: rtl/cov_stream_tx.sv
// cov_stream_tx: snapshots P_kk on the SCU_Done rising edge and streams it one element per beat.
// Define COV_UPPER_TRI_EN to send only the upper triangle.
module cov_stream_tx
    import kf_pkg::*;
#(
    parameter int STATE_DIM = kf_pkg::STATE_DIM,
    parameter int DWIDTH    = kf_pkg::DWIDTH,
    parameter int IDX_W     = $clog2(STATE_DIM)
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic [STATE_DIM-1:0][STATE_DIM-1:0][DWIDTH-1:0] P_kk,
    input  logic                                         SCU_Done,
    output logic [DWIDTH-1:0]                            m_data,
    output logic [IDX_W-1:0]                             m_row,
    output logic [IDX_W-1:0]                             m_col,
    output logic                                         m_valid,
    input  logic                                         m_ready,
    output logic                                         m_last,
    output logic                                         busy,
    output logic                                         tx_done,
    output logic                                         overrun
);

    cov_tx_state_e state, state_nx;

    logic [STATE_DIM-1:0][STATE_DIM-1:0][DWIDTH-1:0] shadow;
    logic [IDX_W-1:0] row, col;
    logic done_q, start, capture, send, accept, is_last;

    cov_index_walker #(
        .STATE_DIM(STATE_DIM),
        .IDX_W    (IDX_W)
    ) u_walker (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (capture),
        .advance(accept),
        .row    (row),
        .col    (col),
        .is_last(is_last)
    );

    // Outputs decode from registered state only, so m_valid never depends on m_ready.
    always_comb begin
        start    = SCU_Done && !done_q;
        send     = state == SEND;
        capture  = state == IDLE && start;
        accept   = send && m_ready;
        state_nx = capture               ? SEND :
                   (accept && is_last)   ? DONE :
                   (state == DONE)       ? IDLE : state;
        m_valid  = send;
        busy     = send;
        tx_done  = state == DONE;
        m_last   = send && is_last;
        m_row    = send ? row : '0;
        m_col    = send ? col : '0;
        m_data   = send ? shadow[row][col] : '0;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state   <= IDLE;
            shadow  <= '0;
            done_q  <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_nx;
            done_q  <= SCU_Done;
            overrun <= overrun || (start && state != IDLE);
            if (capture)
                shadow <= P_kk;
        end

endmodule

// File: tb/tb_cov_stream_tx.sv
// tb_cov_stream_tx: scoreboard bench for cov_stream_tx; follows COV_UPPER_TRI_EN when defined.
module tb_cov_stream_tx;
    import kf_pkg::*;

    localparam int N = 12;
    localparam int W = 64;
`ifdef COV_UPPER_TRI_EN
    localparam bit UPPER = 1'b1;
`else
    localparam bit UPPER = 1'b0;
`endif
    localparam int BEATS = UPPER ? N * (N + 1) / 2 : N * N;

    typedef struct packed {
        idx_t        row;
        idx_t        col;
        logic [63:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic SCU_Done = 1'b0;
    logic m_ready = 1'b0;
    logic [N-1:0][N-1:0][W-1:0] P_kk = '0;
    logic [W-1:0] m_data;
    idx_t m_row, m_col;
    logic m_valid, m_last, busy, tx_done, overrun;

    beat_t sb[$];
    int checks = 0;
    int errors = 0;
    bit aborted;

    always #5 clk = ~clk;

    cov_stream_tx dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .P_kk    (P_kk),
        .SCU_Done(SCU_Done),
        .m_data  (m_data),
        .m_row   (m_row),
        .m_col   (m_col),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_last  (m_last),
        .busy    (busy),
        .tx_done (tx_done),
        .overrun (overrun)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pat(input int i, input int j, input int seed);
        return (64'(seed) << 32) | 64'(i * 16 + j);
    endfunction

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_data"}, m_data, 0);
        chk({tag, "_tags"}, {m_row, m_col}, 0);
        chk({tag, "_valid"}, m_valid, 0);
        chk({tag, "_last"}, m_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_txdone"}, tx_done, 0);
    endtask

    // Drive P_kk, queue the expected traversal, and pulse (or hold) SCU_Done across one edge.
    task automatic start(input int seed, input bit hold);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                P_kk[i][j] = pat(i, j, seed);
        for (int i = 0; i < N; i++)
            for (int j = (UPPER ? i : 0); j < N; j++)
                sb.push_back('{row: idx_t'(i), col: idx_t'(j), data: pat(i, j, seed)});
        SCU_Done = 1'b1;
        @(negedge clk);
        if (!hold) SCU_Done = 1'b0;
    endtask

    task automatic drain(input bit rnd, input int restart_beat, input int abort_beat, output bit ab);
        int n = 0;
        int cyc = 0;
        bit stalled = 1'b0;
        bit pulsed = 1'b0;
        beat_t held;
        beat_t exp;
        ab = 1'b0;
        while (sb.size() > 0 && cyc < 3000) begin
            if (stalled) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_data", m_data, held.data);
                chk("stall_tags", {m_row, m_col}, {held.row, held.col});
            end
            if (n == abort_beat) begin
                rst_n = 1'b0;
                #1;
                chk_idle_zero("abort");
                chk("abort_overrun", overrun, 0);
                repeat (3) begin
                    @(negedge clk);
                    chk("abort_txdone", tx_done, 0);
                    chk("abort_valid", m_valid, 0);
                end
                rst_n = 1'b1;
                sb.delete();
                ab = 1'b1;
                return;
            end
            if (restart_beat >= 0) begin
                SCU_Done = (n == restart_beat) && !pulsed;
                if (SCU_Done) pulsed = 1'b1;
            end
            exp = sb[0];
            chk("valid", m_valid, 1);
            chk("busy", busy, 1);
            chk("data", m_data, exp.data);
            chk("row", m_row, exp.row);
            chk("col", m_col, exp.col);
            chk("last", m_last, sb.size() == 1);
            chk("col_ge_row", (m_col >= m_row) || !UPPER, 1);
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m_ready) begin
                void'(sb.pop_front());
                n++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                held = '{row: m_row, col: m_col, data: m_data};
            end
            @(negedge clk);
            cyc++;
        end
        chk("drained", sb.size(), 0);
        chk("beat_count", n, BEATS);
        chk("done_txdone", tx_done, 1);
        chk("done_busy", busy, 0);
        chk("done_valid", m_valid, 0);
        chk("done_last", m_last, 0);
        @(negedge clk);
        chk("txdone_pulse", tx_done, 0);
        chk("idle_valid", m_valid, 0);
    endtask

    initial begin
        int extra;
        repeat (2) @(negedge clk);
        chk_idle_zero("reset");
        chk("reset_overrun", overrun, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle_zero("idle");

        start(0, 1'b0);
        drain(1'b0, -1, -1, aborted);
        chk("no_overrun", overrun, 0);

        start(1, 1'b0);
        drain(1'b1, -1, -1, aborted);

        start(2, 1'b0);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                P_kk[i][j] = 64'hDEADBEEFDEADBEEF;
        drain(1'b1, -1, -1, aborted);

        start(3, 1'b0);
        drain(1'b0, 40, -1, aborted);
        chk("overrun_set", overrun, 1);
        repeat (5) @(negedge clk);
        chk("overrun_sticky", overrun, 1);

        start(4, 1'b1);
        drain(1'b0, -1, -1, aborted);
        extra = 0;
        repeat (300 - BEATS - 3) begin
            @(negedge clk);
            if (m_valid || tx_done) extra++;
        end
        chk("held_no_retrigger", extra, 0);
        SCU_Done = 1'b0;
        repeat (2) @(negedge clk);

        start(5, 1'b0);
        drain(1'b0, -1, 70, aborted);
        chk("aborted", aborted, 1);
        @(negedge clk);
        chk_idle_zero("post_abort");
        chk("post_abort_overrun", overrun, 0);

        start(6, 1'b0);
        drain(1'b1, -1, -1, aborted);
        chk("final_overrun", overrun, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
